// File: rtl/spike_event_arbiter.sv
// Spike event arbiter: serializes up to 16 per-channel spike pulses into a
// single event stream using a round-robin pointer over a pending vector.
// Optional drop accounting is built when SPIKE_DROP_CNT_EN is defined.
module spike_event_arbiter #(
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] spike_in,
    output logic        spike_valid,
    output logic [3:0]  channel_id,
    output logic        busy
`ifdef SPIKE_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    logic [15:0] pend_q, pend_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        valid_q, valid_d;
    logic [3:0]  id_q, id_d;

    logic [15:0] cand;
    logic [3:0]  grant;
    logic        grant_found;
    logic [15:0] grant_oh;

    // Round-robin search: first set candidate bit at or above ptr, wrapping 15->0.
    always_comb begin
        logic [3:0] idx;
        idx         = '0;
        grant       = '0;
        grant_found = 1'b0;
        cand        = pend_q | spike_in;
        for (int unsigned i = 0; i < 16; i++) begin
            idx = ptr_q + 4'(i);
            if (!grant_found && cand[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
        grant_oh = grant_found ? (16'd1 << grant) : 16'd0;
    end

    // Next-state for pending vector, pointer and registered grant outputs.
    always_comb begin
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        id_d    = id_q;
        if (enable) begin
            valid_d = grant_found;
            // A repeat spike on the channel being granted stays pending as a second event.
            pend_d  = (cand & ~grant_oh) | (pend_q & spike_in & grant_oh);
            if (grant_found) begin
                id_d  = grant;
                ptr_d = grant + 4'd1;
            end
        end else begin
            // Disabled: flush everything, hold pointer and last channel id.
            pend_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign spike_valid = valid_q;
    assign channel_id  = id_q;
    // Reflects registered state only; same-cycle spikes are not included.
    assign busy        = |pend_q;

`ifdef SPIKE_DROP_CNT_EN
    logic [15:0]           drop_vec;
    logic                  drop_hit;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    // A spike arriving on an already-pending, non-granted channel is lost.
    always_comb begin
        drop_vec = pend_q & spike_in & ~grant_oh;
        drop_hit = enable && (|drop_vec);
        drop_d   = drop_q;
        if (drop_hit && (drop_q != {DROP_CNT_W{1'b1}})) begin
            drop_d = drop_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Saturating drop counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule
